// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the VGA framebuffer write arbiter
package vga_pkg;

    localparam int CELLS      = 192;
    localparam int VGA_ADDR_W = 8;
    localparam int VGA_DATA_W = 3;
    localparam int QDEPTH     = 2;

    localparam logic [VGA_ADDR_W-1:0] LAST_CELL = VGA_ADDR_W'(CELLS - 1);
    localparam logic [VGA_ADDR_W-1:0] CELL_LIMIT = VGA_ADDR_W'(CELLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_FILL = 1'b1;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// rtl/vga_write_arbiter_if.sv - CPU, fill-engine and framebuffer write-port bundle
interface vga_write_arbiter_if;
    import vga_pkg::*;

    logic                  iCpuWrEn;
    logic [VGA_ADDR_W-1:0] iCpuAddr;
    logic [VGA_DATA_W-1:0] iCpuData;
    logic                  oCpuStall;
    logic                  iFillStart;
    logic [VGA_DATA_W-1:0] iFillColor;
    logic                  oFillBusy;
    logic                  oFillDone;
    logic                  oRamWrEn;
    logic [VGA_ADDR_W-1:0] oRamAddr;
    logic [VGA_DATA_W-1:0] oRamData;

    // Requester side: CPU execute stage and fill control.
    modport master (
        output iCpuWrEn, iCpuAddr, iCpuData, iFillStart, iFillColor,
        input  oCpuStall, oFillBusy, oFillDone, oRamWrEn, oRamAddr, oRamData
    );

    // Arbiter side.
    modport slave (
        input  iCpuWrEn, iCpuAddr, iCpuData, iFillStart, iFillColor,
        output oCpuStall, oFillBusy, oFillDone, oRamWrEn, oRamAddr, oRamData
    );

endinterface

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - small synchronous FIFO buffering CPU framebuffer writes
module vga_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oFull,
    output logic             oEmpty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    // Flags come from the registered count, so a push on a full queue is refused
    // even when a pop happens on the same edge.
    assign oFull  = (count == (PTR_W+1)'(DEPTH));
    assign oEmpty = (count == '0);
    assign doPush = iPush && !oFull;
    assign doPop  = iPop && !oEmpty;
    assign oData  = mem[rdPtr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge Clock) begin
        if (doPush) begin
            mem[wrPtr] <= iData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - shares the framebuffer write port between CPU queue and fill engine
module vga_write_arbiter
    import vga_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    vga_write_arbiter_if.slave bus
);

    fill_state_t           state;
    fill_state_t           stateNext;
    logic [VGA_ADDR_W-1:0] fillCount;
    logic [VGA_DATA_W-1:0] fillColor;
    logic                  lastGrant;

    logic                             qPush;
    logic                             qFull;
    logic                             qEmpty;
    logic [VGA_ADDR_W+VGA_DATA_W-1:0] qData;

    logic cpuReq;
    logic fillReq;
    logic grantCpu;
    logic grantFill;

    // Out-of-range addresses are dropped here and never occupy a queue slot.
    assign qPush = bus.iCpuWrEn && (bus.iCpuAddr < CELL_LIMIT);

    vga_wr_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (VGA_ADDR_W + VGA_DATA_W)
    ) u_fifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .iPush  (qPush),
        .iData  ({bus.iCpuAddr, bus.iCpuData}),
        .iPop   (grantCpu),
        .oData  (qData),
        .oFull  (qFull),
        .oEmpty (qEmpty)
    );

    assign cpuReq        = !qEmpty;
    assign fillReq       = (state == FILL);
    assign bus.oCpuStall = qFull;
    assign bus.oFillBusy = (state == FILL) || (state == DONE);

    // Single requester wins outright; under contention the side not granted last wins.
    always_comb begin
        grantCpu  = 1'b0;
        grantFill = 1'b0;
        if (cpuReq && fillReq) begin
            if (lastGrant == GRANT_FILL) begin
                grantCpu = 1'b1;
            end else begin
                grantFill = 1'b1;
            end
        end else begin
            grantCpu  = cpuReq;
            grantFill = fillReq;
        end
    end

    // Fill sequencing: start only from IDLE, leave FILL on the grant of the last cell.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.iFillStart) stateNext = FILL;
            FILL:    if (grantFill && (fillCount == LAST_CELL)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Fill state, cell counter, latched colour and grant history.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            fillCount <= '0;
            fillColor <= '0;
            lastGrant <= GRANT_FILL;
        end else begin
            state <= stateNext;
            if ((state == IDLE) && bus.iFillStart) begin
                fillColor <= bus.iFillColor;
                fillCount <= '0;
            end else if (grantFill && (fillCount != LAST_CELL)) begin
                fillCount <= fillCount + 1'b1;
            end
            if (grantCpu) begin
                lastGrant <= GRANT_CPU;
            end else if (grantFill) begin
                lastGrant <= GRANT_FILL;
            end
        end
    end

    // Registered write port; address and data hold between writes. The done pulse
    // follows the DONE cycle so it lands just after the last fill write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bus.oRamWrEn  <= 1'b0;
            bus.oRamAddr  <= '0;
            bus.oRamData  <= '0;
            bus.oFillDone <= 1'b0;
        end else begin
            bus.oRamWrEn  <= grantCpu || grantFill;
            bus.oFillDone <= (state == DONE);
            if (grantCpu) begin
                {bus.oRamAddr, bus.oRamData} <= qData;
            end else if (grantFill) begin
                bus.oRamAddr <= fillCount;
                bus.oRamData <= fillColor;
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - scoreboard bench for the VGA framebuffer write arbiter
module tb_vga_write_arbiter;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    vga_write_arbiter_if vif ();

    vga_write_arbiter dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (vif)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0] addr;
        logic [2:0] data;
    } wr_t;

    wr_t        cpuQ[$];
    logic       monEn = 1'b0;
    logic       fillActiveExp = 1'b0;
    logic       checkAlt = 1'b0;
    logic [2:0] fillColorExp = 3'b010;
    int         fillNext = 0;
    int         fillWrites = 0;
    int         doneCount = 0;
    int         altViol = 0;
    logic       prevFill = 1'b0;
    logic       prevCpu = 1'b0;
    logic       curFill;
    logic       curCpu;
    wr_t        gotWr;
    wr_t        expWr;

    // Write monitor: fill writes checked against a running address, CPU writes popped from the queue.
    always @(negedge Clock) begin
        curFill = 1'b0;
        curCpu  = 1'b0;
        if (monEn && !Reset) begin
            if (vif.oFillDone) doneCount++;
            if (vif.oRamWrEn) begin
                gotWr = {vif.oRamAddr, vif.oRamData};
                checks++;
                if (fillActiveExp && (vif.oRamData == fillColorExp)) begin
                    curFill = 1'b1;
                    if (vif.oRamAddr !== 8'(fillNext)) begin
                        errors++;
                        $display("FAIL fill_addr got %0d expected %0d", vif.oRamAddr, fillNext);
                    end
                    fillNext++;
                    fillWrites++;
                end else begin
                    curCpu = 1'b1;
                    if (cpuQ.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write got addr %0d data %0d expected no write", gotWr.addr, gotWr.data);
                    end else begin
                        expWr = cpuQ.pop_front();
                        if (gotWr !== expWr) begin
                            errors++;
                            $display("FAIL cpu_write got addr %0d data %0d expected addr %0d data %0d",
                                     gotWr.addr, gotWr.data, expWr.addr, expWr.data);
                        end
                    end
                end
            end
            if (checkAlt) begin
                if (curFill && prevFill) altViol++;
                if (curCpu && prevCpu && (fillNext >= 1) && (fillNext <= 191)) altViol++;
            end
        end
        prevFill = curFill;
        prevCpu  = curCpu;
    end

    // Drive one CPU request at a negedge; record it when the coming edge will accept it.
    task automatic cpu_drive(input logic en, input logic [7:0] a, input logic [2:0] d);
        vif.iCpuWrEn = en;
        vif.iCpuAddr = a;
        vif.iCpuData = d;
        if (en && !vif.oCpuStall && (a < 8'd192)) cpuQ.push_back({a, d});
    endtask

    task automatic start_fill(input logic [2:0] color);
        @(negedge Clock);
        vif.iFillStart = 1'b1;
        vif.iFillColor = color;
        @(negedge Clock);
        vif.iFillStart = 1'b0;
    endtask

    task automatic wait_fill_done(input int maxN, output int doneAt, output int firstAddr, output int wrCnt);
        doneAt = -1;
        firstAddr = -1;
        wrCnt = 0;
        for (int n = 1; n <= maxN; n++) begin
            @(negedge Clock);
            if (vif.oRamWrEn) begin
                if (firstAddr < 0) firstAddr = int'(vif.oRamAddr);
                wrCnt++;
            end
            if (vif.oFillDone) begin
                doneAt = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #12;
        checks++;
        if ({vif.oRamWrEn, vif.oRamAddr, vif.oRamData, vif.oFillBusy, vif.oFillDone, vif.oCpuStall} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected all zero",
                     {vif.oRamWrEn, vif.oRamAddr, vif.oRamData, vif.oFillBusy, vif.oFillDone, vif.oCpuStall});
        end
        @(negedge Clock);
        Reset = 1'b0;
        monEn = 1'b1;
    endtask

    task automatic test_single_write();
        fillActiveExp = 1'b0;
        @(negedge Clock);
        cpu_drive(1'b1, 8'h25, 3'b101);
        @(negedge Clock);
        cpu_drive(1'b0, 8'h00, 3'b000);
        checks++;
        if (vif.oRamWrEn !== 1'b0) begin
            errors++;
            $display("FAIL single_early got %b expected 0", vif.oRamWrEn);
        end
        @(negedge Clock);
        checks++;
        if ({vif.oRamWrEn, vif.oRamAddr, vif.oRamData} !== {1'b1, 8'h25, 3'd5}) begin
            errors++;
            $display("FAIL single_write got en %b addr %h data %0d expected en 1 addr 25 data 5",
                     vif.oRamWrEn, vif.oRamAddr, vif.oRamData);
        end
        @(negedge Clock);
        checks++;
        if ({vif.oRamWrEn, vif.oRamAddr, vif.oRamData} !== {1'b0, 8'h25, 3'd5}) begin
            errors++;
            $display("FAIL single_hold got en %b addr %h data %0d expected en 0 addr 25 data 5",
                     vif.oRamWrEn, vif.oRamAddr, vif.oRamData);
        end
    endtask

    task automatic test_bad_addr();
        int stallSeen;
        int wrSeen;
        stallSeen = 0;
        wrSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (vif.oCpuStall) stallSeen++;
            if (vif.oRamWrEn) wrSeen++;
            cpu_drive(1'b1, 8'd200, 3'b001);
        end
        @(negedge Clock);
        cpu_drive(1'b0, 8'h00, 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (vif.oCpuStall) stallSeen++;
            if (vif.oRamWrEn) wrSeen++;
        end
        checks++;
        if (stallSeen != 0 || wrSeen != 0) begin
            errors++;
            $display("FAIL bad_addr got stalls %0d writes %0d expected 0 and 0", stallSeen, wrSeen);
        end
        @(negedge Clock);
        cpu_drive(1'b1, 8'd191, 3'b011);
        @(negedge Clock);
        cpu_drive(1'b0, 8'h00, 3'b000);
        @(negedge Clock);
        checks++;
        if ({vif.oRamWrEn, vif.oRamAddr, vif.oRamData} !== {1'b1, 8'd191, 3'd3}) begin
            errors++;
            $display("FAIL after_bad_addr got en %b addr %0d data %0d expected en 1 addr 191 data 3",
                     vif.oRamWrEn, vif.oRamAddr, vif.oRamData);
        end
    endtask

    task automatic test_fill_alone();
        int firstWr, lastWr, wrCnt, doneAt, busyDrop;
        fillColorExp = 3'b010;
        fillActiveExp = 1'b1;
        fillNext = 0;
        fillWrites = 0;
        doneCount = 0;
        start_fill(3'b010);
        checks++;
        if (vif.oFillBusy !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy_start got %b expected 1", vif.oFillBusy);
        end
        firstWr = -1; lastWr = -1; wrCnt = 0; doneAt = -1; busyDrop = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge Clock);
            if (vif.oRamWrEn) begin
                if (firstWr < 0) firstWr = n;
                lastWr = n;
                wrCnt++;
            end
            if (vif.oFillDone) begin
                doneAt = n;
                break;
            end
            if (!vif.oFillBusy) busyDrop++;
        end
        checks++;
        if (firstWr != 1 || lastWr != 192 || wrCnt != 192) begin
            errors++;
            $display("FAIL fill_span got first %0d last %0d count %0d expected 1 192 192", firstWr, lastWr, wrCnt);
        end
        checks++;
        if (doneAt != 193) begin
            errors++;
            $display("FAIL fill_done_time got %0d expected 193", doneAt);
        end
        checks++;
        if (busyDrop != 0) begin
            errors++;
            $display("FAIL fill_busy got %0d low cycles expected 0", busyDrop);
        end
        @(negedge Clock);
        checks++;
        if (doneCount != 1 || vif.oFillDone !== 1'b0 || fillWrites != 192) begin
            errors++;
            $display("FAIL fill_done_pulse got pulses %0d done %b writes %0d expected 1 0 192",
                     doneCount, vif.oFillDone, fillWrites);
        end
    endtask

    task automatic test_contention();
        int doneAt, lastFillAt, stallSeen;
        fillColorExp = 3'b010;
        fillActiveExp = 1'b1;
        fillNext = 0;
        fillWrites = 0;
        doneCount = 0;
        altViol = 0;
        checkAlt = 1'b1;
        doneAt = -1;
        lastFillAt = -1;
        stallSeen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clock);
            if (vif.oRamWrEn && vif.oRamData == 3'b010 && vif.oRamAddr == 8'd191) lastFillAt = i - 2;
            if (vif.oFillDone) doneAt = i - 2;
            if (vif.oCpuStall) stallSeen++;
            cpu_drive(1'b1, 8'(i % 192), {1'b1, i[1:0]});
            vif.iFillStart = (i == 2);
            vif.iFillColor = 3'b010;
            if (doneAt >= 0) break;
        end
        @(negedge Clock);
        cpu_drive(1'b0, 8'h00, 3'b000);
        repeat (8) @(negedge Clock);
        checkAlt = 1'b0;
        checks++;
        if (doneAt < 0 || lastFillAt < 192 || lastFillAt > 384) begin
            errors++;
            $display("FAIL contention_time got last fill %0d done %0d expected last fill within 192..384",
                     lastFillAt, doneAt);
        end
        checks++;
        if (stallSeen == 0) begin
            errors++;
            $display("FAIL contention_stall got %0d stall cycles expected nonzero", stallSeen);
        end
        checks++;
        if (cpuQ.size() != 0) begin
            errors++;
            $display("FAIL contention_lost got %0d pending writes expected 0", cpuQ.size());
        end
        checks++;
        if (altViol != 0) begin
            errors++;
            $display("FAIL contention_alternation got %0d violations expected 0", altViol);
        end
        checks++;
        if (fillWrites != 192 || doneCount != 1) begin
            errors++;
            $display("FAIL contention_fill got writes %0d pulses %0d expected 192 1", fillWrites, doneCount);
        end
    endtask

    task automatic test_reset_mid_fill();
        int found, doneAt, firstAddr, wrCnt;
        fillColorExp = 3'b011;
        fillActiveExp = 1'b1;
        fillNext = 0;
        fillWrites = 0;
        doneCount = 0;
        found = 0;
        start_fill(3'b011);
        for (int n = 0; n < 300; n++) begin
            @(negedge Clock);
            if (vif.oRamWrEn && vif.oRamAddr == 8'd100) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL reset_mid_reach got no write to cell 100 expected one");
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({vif.oRamWrEn, vif.oRamAddr, vif.oRamData, vif.oFillBusy, vif.oFillDone, vif.oCpuStall} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b expected all zero",
                     {vif.oRamWrEn, vif.oRamAddr, vif.oRamData, vif.oFillBusy, vif.oFillDone, vif.oCpuStall});
        end
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        checks++;
        if (doneCount != 0 || vif.oFillBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort got pulses %0d busy %b expected 0 0", doneCount, vif.oFillBusy);
        end
        fillNext = 0;
        fillWrites = 0;
        start_fill(3'b011);
        wait_fill_done(400, doneAt, firstAddr, wrCnt);
        @(negedge Clock);
        checks++;
        if (firstAddr != 0 || doneAt < 0 || fillWrites != 192 || doneCount != 1) begin
            errors++;
            $display("FAIL reset_mid_refill got first %0d done %0d writes %0d pulses %0d expected 0 >=0 192 1",
                     firstAddr, doneAt, fillWrites, doneCount);
        end
    endtask

    task automatic test_restart_ignored();
        int found, doneAt, firstAddr, wrCnt;
        fillColorExp = 3'b110;
        fillActiveExp = 1'b1;
        fillNext = 0;
        fillWrites = 0;
        doneCount = 0;
        found = 0;
        start_fill(3'b110);
        for (int n = 0; n < 300; n++) begin
            @(negedge Clock);
            if (vif.oRamWrEn && vif.oRamAddr == 8'd50) begin
                found = 1;
                break;
            end
        end
        vif.iFillStart = 1'b1;
        vif.iFillColor = 3'b001;
        @(negedge Clock);
        vif.iFillStart = 1'b0;
        wait_fill_done(400, doneAt, firstAddr, wrCnt);
        repeat (5) @(negedge Clock);
        checks++;
        if (found == 0 || doneAt < 0 || fillWrites != 192 || doneCount != 1) begin
            errors++;
            $display("FAIL restart_ignored got found %0d done %0d writes %0d pulses %0d expected 1 >=0 192 1",
                     found, doneAt, fillWrites, doneCount);
        end
        checks++;
        if (vif.oFillBusy !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle got busy %b expected 0", vif.oFillBusy);
        end
    endtask

    initial begin
        Reset = 1'b1;
        vif.iCpuWrEn = 1'b0;
        vif.iCpuAddr = '0;
        vif.iCpuData = '0;
        vif.iFillStart = 1'b0;
        vif.iFillColor = '0;
        test_reset();
        test_single_write();
        test_bad_addr();
        test_fill_alone();
        test_contention();
        test_reset_mid_fill();
        test_restart_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
